// File: rtl/alut_lkup_pkg.sv
// Shared register map, command encoding, FSM states and write-sequence table for the ALUT
// lookup master.
package alut_lkup_pkg;

  localparam logic [6:0] AddrCmd     = 7'h00;
  localparam logic [6:0] AddrDaddrLo = 7'h08;
  localparam logic [6:0] AddrDaddrHi = 7'h0C;
  localparam logic [6:0] AddrSaddrLo = 7'h10;
  localparam logic [6:0] AddrSaddrHi = 7'h14;
  localparam logic [6:0] AddrStatus  = 7'h18;
  localparam logic [6:0] AddrDport   = 7'h1C;

  localparam logic [1:0] CmdCheck   = 2'b01;
  localparam logic [2:0] LastWrIdx  = 3'd4;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StWait,
    StPoll,
    StRd,
    StRsp
  } state_e;

  typedef struct packed {
    logic [6:0]  addr;
    logic [31:0] data;
  } apb_wr_t;

  // Address/data of write number idx in the lookup command sequence.
  function automatic apb_wr_t wr_entry(input logic [2:0]  idx,
                                       input logic [47:0] daddr,
                                       input logic [47:0] saddr,
                                       input logic [1:0]  sport);
    apb_wr_t e;
    case (idx)
      3'd0:    e = '{addr: AddrDaddrLo, data: daddr[31:0]};
      3'd1:    e = '{addr: AddrDaddrHi, data: {16'h0, daddr[47:32]}};
      3'd2:    e = '{addr: AddrSaddrLo, data: saddr[31:0]};
      3'd3:    e = '{addr: AddrSaddrHi, data: {14'h0, sport, saddr[47:32]}};
      default: e = '{addr: AddrCmd, data: {30'h0, CmdCheck}};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/alut_lkup_apb_xfer.sv
// Single APB transfer engine: start loads a SETUP cycle, ACCESS follows with no wait states.
// A start during ACCESS chains the next transfer back-to-back.
module alut_lkup_apb_xfer (
  input  logic        pclk,
  input  logic        n_p_reset,
  input  logic        start,
  input  logic        write,
  input  logic [6:0]  addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [6:0]  paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata
);

  logic        psel_q, penable_q, pwrite_q;
  logic [6:0]  paddr_q;
  logic [31:0] pwdata_q;

  always_ff @(posedge pclk or negedge n_p_reset) begin
    if (!n_p_reset) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else if (start) begin
      psel_q    <= 1'b1;
      penable_q <= 1'b0;
      pwrite_q  <= write;
      paddr_q   <= addr;
      pwdata_q  <= write ? wdata : '0;
    end else if (psel_q) begin
      // SETUP -> ACCESS, ACCESS -> idle; address/data are left untouched
      penable_q <= ~penable_q;
      psel_q    <= ~penable_q;
    end
  end

  assign done    = psel_q & penable_q;
  assign rdata   = prdata;
  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;

endmodule

// File: rtl/alut_lookup_master.sv
// ALUT lookup master: writes the lookup command over APB, polls STATUS, reads DPORT and returns
// it on a valid/ready response. Optional poll timeout: ALUT_LKUP_TIMEOUT_EN.
module alut_lookup_master
  import alut_lkup_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        pclk,
  input  logic        n_p_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [47:0] req_daddr,
  input  logic [47:0] req_saddr,
  input  logic [1:0]  req_sport,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [4:0]  rsp_dport,
  output logic        rsp_err,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [6:0]  paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata
);

  state_e      state_q, state_d;
  logic [2:0]  wr_idx_q, wr_idx_d;
  logic        wait_q, wait_d;
  logic [47:0] daddr_q, daddr_d, saddr_q, saddr_d;
  logic [1:0]  sport_q, sport_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [4:0]  rsp_dport_q, rsp_dport_d;

  logic        xfer_start, xfer_write, xfer_done;
  logic [6:0]  xfer_addr;
  logic [31:0] xfer_wdata, xfer_rdata;
  apb_wr_t     wr_ent;
  logic        accept, poll_busy_done, poll_expired;

  assign req_ready      = (state_q == StIdle);
  assign accept         = req_valid & req_ready;
  assign poll_busy_done = (state_q == StPoll) & xfer_done & xfer_rdata[0];

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    wait_d      = wait_q;
    daddr_d     = daddr_q;
    saddr_d     = saddr_q;
    sport_d     = sport_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dport_d = rsp_dport_q;
    xfer_start  = 1'b0;
    xfer_write  = 1'b0;
    xfer_addr   = AddrStatus;
    xfer_wdata  = '0;
    wr_ent      = wr_entry(wr_idx_q + 3'd1, daddr_q, saddr_q, sport_q);

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          // First write is issued straight from the request inputs to save a cycle
          wr_ent     = wr_entry(3'd0, req_daddr, req_saddr, req_sport);
          daddr_d    = req_daddr;
          saddr_d    = req_saddr;
          sport_d    = req_sport;
          wr_idx_d   = 3'd0;
          xfer_start = 1'b1;
          xfer_write = 1'b1;
          xfer_addr  = wr_ent.addr;
          xfer_wdata = wr_ent.data;
          state_d    = StWr;
        end
      end
      StWr: begin
        if (xfer_done) begin
          if (wr_idx_q == LastWrIdx) begin
            wr_idx_d = 3'd0;
            wait_d   = 1'b0;
            state_d  = StWait;
          end else begin
            wr_idx_d   = wr_idx_q + 3'd1;
            xfer_start = 1'b1;
            xfer_write = 1'b1;
            xfer_addr  = wr_ent.addr;
            xfer_wdata = wr_ent.data;
          end
        end
      end
      StWait: begin
        wait_d = 1'b1;
        if (wait_q) begin
          wait_d     = 1'b0;
          xfer_start = 1'b1;
          state_d    = StPoll;
        end
      end
      StPoll: begin
        if (xfer_done) begin
          if (!xfer_rdata[0]) begin
            xfer_start = 1'b1;
            xfer_addr  = AddrDport;
            state_d    = StRd;
          end else if (poll_expired) begin
            rsp_dport_d = '0;
            rsp_valid_d = 1'b1;
            state_d     = StRsp;
          end else begin
            xfer_start = 1'b1;
          end
        end
      end
      StRd: begin
        if (xfer_done) begin
          rsp_dport_d = xfer_rdata[4:0];
          rsp_valid_d = 1'b1;
          state_d     = StRsp;
        end
      end
      StRsp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk or negedge n_p_reset) begin
    if (!n_p_reset) begin
      state_q     <= StIdle;
      wr_idx_q    <= '0;
      wait_q      <= 1'b0;
      daddr_q     <= '0;
      saddr_q     <= '0;
      sport_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dport_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      wait_q      <= wait_d;
      daddr_q     <= daddr_d;
      saddr_q     <= saddr_d;
      sport_q     <= sport_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dport_q <= rsp_dport_d;
    end
  end

`ifdef ALUT_LKUP_TIMEOUT_EN
  localparam logic [7:0] PollLast = 8'(TIMEOUT_CYC - 1);

  logic [7:0] poll_cnt_q;
  logic       rsp_err_q;

  assign poll_expired = (poll_cnt_q == PollLast);

  always_ff @(posedge pclk or negedge n_p_reset) begin
    if (!n_p_reset) begin
      poll_cnt_q <= '0;
      rsp_err_q  <= 1'b0;
    end else if (accept) begin
      poll_cnt_q <= '0;
      rsp_err_q  <= 1'b0;
    end else if ((state_q == StPoll) && xfer_done) begin
      poll_cnt_q <= poll_cnt_q + 8'd1;
      if (poll_busy_done && poll_expired) rsp_err_q <= 1'b1;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC == 0) ^ accept ^ poll_busy_done;
  assign poll_expired   = 1'b0;
  assign rsp_err        = 1'b0;
`endif

  logic unused_rdata;
  assign unused_rdata = ^xfer_rdata[31:5];

  assign rsp_valid = rsp_valid_q;
  assign rsp_dport = rsp_dport_q;

  alut_lkup_apb_xfer u_xfer (
    .pclk      (pclk),
    .n_p_reset (n_p_reset),
    .start     (xfer_start),
    .write     (xfer_write),
    .addr      (xfer_addr),
    .wdata     (xfer_wdata),
    .done      (xfer_done),
    .rdata     (xfer_rdata),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata)
  );

endmodule

// File: tb/tb_alut_lookup_master.sv
// Self-checking bench for alut_lookup_master: APB slave model, randomized lookups, reset and
// back-pressure scenarios; timeout scenario when ALUT_LKUP_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_alut_lookup_master;

  localparam int ToCyc = 4;

  logic        pclk = 1'b0;
  logic        n_p_reset = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [47:0] req_daddr = '0, req_saddr = '0;
  logic [1:0]  req_sport = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [4:0]  rsp_dport;
  logic        psel, penable, pwrite;
  logic [6:0]  paddr;
  logic [31:0] pwdata, prdata;

  int passed = 0;
  int total  = 0;

  // Slave model state
  int          busy_polls = 0;
  int          status_setups = 0;
  logic [4:0]  dport_val = '0;
  logic [31:0] junk = '0;
  logic        busy_bit;
  logic [6:0]  log_addr[$];
  logic [31:0] log_data[$];
  logic        log_wr[$];
  logic [6:0]  exp_addr[$];
  logic [31:0] exp_data[$];
  logic        exp_wr[$];

  always #5 pclk = ~pclk;

  assign busy_bit = (status_setups <= busy_polls);
  assign prdata = (paddr == 7'h18) ? {junk[31:1], busy_bit} :
                  (paddr == 7'h1C) ? {junk[31:5], dport_val} : junk;

  alut_lookup_master #(.TIMEOUT_CYC(ToCyc)) dut (
    .pclk      (pclk),
    .n_p_reset (n_p_reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_daddr (req_daddr),
    .req_saddr (req_saddr),
    .req_sport (req_sport),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dport (rsp_dport),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata)
  );

  // APB protocol monitor: every ACCESS must follow a SETUP with identical addr/data/dir.
  logic        in_setup = 1'b0;
  logic [6:0]  su_addr;
  logic [31:0] su_data;
  logic        su_wr;
  always @(negedge pclk) begin
    if (n_p_reset && (in_setup || (psel && penable))) begin
      total++;
      if (!in_setup || !(psel && penable) || paddr !== su_addr || pwdata !== su_data ||
          pwrite !== su_wr)
        $display("FAIL apb_phase: setup=%b psel=%b penable=%b addr=%h/%h data=%h/%h wr=%b/%b",
                 in_setup, psel, penable, paddr, su_addr, pwdata, su_data, pwrite, su_wr);
      else passed++;
    end
    in_setup = n_p_reset && psel && !penable;
    if (in_setup) begin
      su_addr = paddr;
      su_data = pwdata;
      su_wr   = pwrite;
      if (paddr == 7'h18) status_setups++;
    end
    if (psel && penable) begin
      log_addr.push_back(paddr);
      log_data.push_back(pwdata);
      log_wr.push_back(pwrite);
    end
  end

  // Reference model: expected APB transfer list for one lookup.
  function automatic void build_exp(input logic [47:0] da, input logic [47:0] sa,
                                    input logic [1:0] sp, input int polls, input bit rd);
    exp_addr = '{7'h08, 7'h0C, 7'h10, 7'h14, 7'h00};
    exp_data = '{da[31:0], {16'h0, da[47:32]}, sa[31:0], {14'h0, sp, sa[47:32]}, 32'h1};
    exp_wr   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    repeat (polls) begin
      exp_addr.push_back(7'h18); exp_data.push_back(32'h0); exp_wr.push_back(1'b0);
    end
    if (rd) begin
      exp_addr.push_back(7'h1C); exp_data.push_back(32'h0); exp_wr.push_back(1'b0);
    end
  endfunction

  function automatic int exp_latency(input int polls, input bit rd);
    return 10 + 2 + 2 * polls + (rd ? 2 : 0) + 1;
  endfunction

  function automatic logic [47:0] rand48();
    return 48'({$urandom(), $urandom()});
  endfunction

  // Issue one request and return at the first negedge with rsp_valid high (or budget spent).
  task automatic do_lookup(input logic [47:0] da, input logic [47:0] sa, input logic [1:0] sp,
                           input int busy, input logic [4:0] dp, output int lat);
    int n;
    @(negedge pclk);
    log_addr.delete(); log_data.delete(); log_wr.delete();
    status_setups = 0;
    busy_polls = busy;
    dport_val  = dp;
    junk       = $urandom();
    req_valid  = 1'b1;
    req_daddr  = da;
    req_saddr  = sa;
    req_sport  = sp;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge pclk); n++; end
    @(negedge pclk);
    req_valid = 1'b0;
    req_daddr = rand48();
    req_saddr = rand48();
    req_sport = 2'($urandom());
    lat = 1;
    while (!rsp_valid && lat < 400) begin @(negedge pclk); lat++; end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_p_reset = 1'b0;
    #1;
    total++;
    if ({psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_dport, rsp_err, req_ready} !==
        {3'b000, 7'h0, 32'h0, 1'b0, 5'h0, 1'b0, 1'b1})
      $display("FAIL reset_outputs: got psel=%b pen=%b pw=%b paddr=%h pwdata=%h rv=%b dp=%b err=%b rr=%b",
               psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_dport, rsp_err, req_ready);
    else passed++;
    repeat (3) @(negedge pclk);
    n_p_reset = 1'b1;
    @(negedge pclk);
    total++;
    if (psel !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL reset_release: got psel=%b req_ready=%b, want 0/1", psel, req_ready);
    else passed++;
  endtask

  task automatic check_lookup(input string tag, input int lat, input int polls, input bit rd,
                              input logic [4:0] dp, input logic err);
    total++;
    if (lat !== exp_latency(polls, rd))
      $display("FAIL %s_latency: got %0d want %0d", tag, lat, exp_latency(polls, rd));
    else passed++;
    total++;
    if (rsp_valid !== 1'b1 || rsp_dport !== dp || rsp_err !== err)
      $display("FAIL %s_rsp: got valid=%b dport=%b err=%b want 1/%b/%b",
               tag, rsp_valid, rsp_dport, rsp_err, dp, err);
    else passed++;
    total++;
    if (log_addr.size() != exp_addr.size())
      $display("FAIL %s_count: got %0d transfers want %0d", tag, log_addr.size(), exp_addr.size());
    else passed++;
    foreach (exp_addr[i]) begin
      if (i < log_addr.size()) begin
        total++;
        if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i] || log_wr[i] !== exp_wr[i])
          $display("FAIL %s_xfer%0d: got addr=%h data=%h wr=%b want addr=%h data=%h wr=%b", tag,
                   i, log_addr[i], log_data[i], log_wr[i], exp_addr[i], exp_data[i], exp_wr[i]);
        else passed++;
      end
    end
  endtask

  task automatic test_directed();
    int lat;
    do_lookup(48'h0011_2233_4455, 48'h0066_7788_99AA, 2'd2, 0, 5'b0_0100, lat);
    build_exp(48'h0011_2233_4455, 48'h0066_7788_99AA, 2'd2, 1, 1'b1);
    check_lookup("directed", lat, 1, 1'b1, 5'b0_0100, 1'b0);
    finish_rsp();
  endtask

  task automatic test_busy_polls();
    int lat;
    logic [47:0] da, sa;
    da = rand48();
    sa = rand48();
    do_lookup(da, sa, 2'd1, 3, 5'b1_0000, lat);
    build_exp(da, sa, 2'd1, 4, 1'b1);
    check_lookup("busy3", lat, 4, 1'b1, 5'b1_0000, 1'b0);
    total++;
    if (lat !== 23) $display("FAIL busy3_cycle: got %0d want 23", lat);
    else passed++;
    finish_rsp();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [47:0] da2, sa2;
    da2 = rand48();
    sa2 = rand48();
    do_lookup(rand48(), rand48(), 2'd3, 0, 5'b0_1000, lat);
    req_valid = 1'b1;
    req_daddr = da2;
    req_saddr = sa2;
    req_sport = 2'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      total++;
      if (rsp_valid !== 1'b1 || rsp_dport !== 5'b0_1000 || req_ready !== 1'b0 || psel !== 1'b0)
        $display("FAIL bp_hold%0d: got valid=%b dport=%b req_ready=%b psel=%b want 1/01000/0/0",
                 i, rsp_valid, rsp_dport, req_ready, psel);
      else passed++;
    end
    rsp_ready = 1'b1;
    log_addr.delete(); log_data.delete(); log_wr.delete();
    status_setups = 0;
    busy_polls = 0;
    dport_val  = 5'b0_0010;
    @(negedge pclk);
    rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || psel !== 1'b0)
      $display("FAIL bp_handshake: got valid=%b req_ready=%b psel=%b want 0/1/0",
               rsp_valid, req_ready, psel);
    else passed++;
    @(negedge pclk);
    req_valid = 1'b0;
    total++;
    if (req_ready !== 1'b0 || psel !== 1'b1 || penable !== 1'b0 || paddr !== 7'h08 ||
        pwdata !== da2[31:0])
      $display("FAIL bp_next_accept: got rr=%b psel=%b pen=%b paddr=%h pwdata=%h want 0/1/0/08/%h",
               req_ready, psel, penable, paddr, pwdata, da2[31:0]);
    else passed++;
    lat = 1;
    while (!rsp_valid && lat < 400) begin @(negedge pclk); lat++; end
    build_exp(da2, sa2, 2'd0, 1, 1'b1);
    check_lookup("bp_second", lat, 1, 1'b1, 5'b0_0010, 1'b0);
    finish_rsp();
  endtask

  task automatic test_random();
    int lat, busy;
    logic [47:0] da, sa;
    logic [1:0]  sp;
    logic [4:0]  dp;
    for (int k = 0; k < 6; k++) begin
      da   = rand48();
      sa   = rand48();
      sp   = 2'($urandom());
      busy = $urandom_range(0, 3);
      dp   = 5'b1 << $urandom_range(0, 4);
      do_lookup(da, sa, sp, busy, dp, lat);
      build_exp(da, sa, sp, busy + 1, 1'b1);
      check_lookup($sformatf("rand%0d", k), lat, busy + 1, 1'b1, dp, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge pclk);
      finish_rsp();
    end
  endtask

  task automatic test_reset_midwrite();
    int n, lat, seen;
    logic [47:0] da, sa;
    @(negedge pclk);
    busy_polls = 0;
    req_valid  = 1'b1;
    req_daddr  = rand48();
    req_saddr  = rand48();
    req_sport  = 2'd1;
    @(negedge pclk);
    req_valid = 1'b0;
    n = 0;
    while (!(psel && !penable && paddr == 7'h10) && n < 30) begin @(negedge pclk); n++; end
    total++;
    if (n >= 30) $display("FAIL midwrite_reach: got no 0x10 setup within 30 cycles");
    else passed++;
    n_p_reset = 1'b0;
    #1;
    total++;
    if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1 ||
        paddr !== 7'h0 || pwdata !== 32'h0)
      $display("FAIL midwrite_async: got psel=%b pen=%b rv=%b rr=%b paddr=%h pwdata=%h",
               psel, penable, rsp_valid, req_ready, paddr, pwdata);
    else passed++;
    repeat (3) @(negedge pclk);
    n_p_reset = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge pclk);
      if (rsp_valid || psel) seen++;
    end
    total++;
    if (seen != 0) $display("FAIL midwrite_no_rsp: got %0d active cycles want 0", seen);
    else passed++;
    da = rand48();
    sa = rand48();
    do_lookup(da, sa, 2'd2, 1, 5'b0_0001, lat);
    build_exp(da, sa, 2'd2, 2, 1'b1);
    check_lookup("after_reset", lat, 2, 1'b1, 5'b0_0001, 1'b0);
    finish_rsp();
  endtask

`ifdef ALUT_LKUP_TIMEOUT_EN
  task automatic test_timeout();
    int lat;
    logic [47:0] da, sa;
    da = rand48();
    sa = rand48();
    do_lookup(da, sa, 2'd3, 1000, 5'b1_1111, lat);
    build_exp(da, sa, 2'd3, ToCyc, 1'b0);
    check_lookup("timeout", lat, ToCyc, 1'b0, 5'b0_0000, 1'b1);
    finish_rsp();
    do_lookup(da, sa, 2'd3, 0, 5'b0_0100, lat);
    build_exp(da, sa, 2'd3, 1, 1'b1);
    check_lookup("post_timeout", lat, 1, 1'b1, 5'b0_0100, 1'b0);
    finish_rsp();
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_busy_polls();
    test_backpressure();
    test_random();
    test_reset_midwrite();
`ifdef ALUT_LKUP_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
